bira_fault_buffer: RTL
======================

# bira_fault_buffer

Elastic fault queue between the BIST engine and the BIRA top. It captures per-cycle fault reports (row, column, column flag, bank) from BIST, merges back-to-back repeats of the same cell group, and presents them to BIRA one at a time over a valid/ready handshake. It also throttles BIST when nearly full and forwards end-of-test only after every buffered fault has been consumed.

## Interface
- DEPTH, 8, queue entries (power of two, ≥4)
- AW, 3, log2(DEPTH)
- clk  in  1  100 MHz system clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- fault_detect  in  1  BIST fault strobe, one report per asserted cycle
- row_add_in  in  10  fault row address
- col_add_in  in  10  fault column address
- col_flag  in  8  failing-bit flags within the column group
- bank_in  in  2  fault bank
- test_end  in  1  BIST test-complete level/pulse
- early_term  in  1  abort request from BIRA
- bira_ready  in  1  BIRA accepts the head entry this cycle
- fault_valid  out  1  head entry valid
- row_addr  out  10  head row
- col_addr  out  10  head column
- col_flag_out  out  8  head flags (OR-merged)
- bank_addr  out  2  head bank
- bist_hold  out  1  stall request to BIST
- test_end_out  out  1  all faults delivered after test_end
- aborted  out  1  early_term received
- overflow  out  1  sticky: a report was dropped
- count  out  AW+1  current occupancy

## Operation
- FSM states: COLLECT (after reset), DRAIN, DONE, ABORT.
- COLLECT: accept reports. test_end=1 -> DRAIN. A fault_detect in the same cycle as test_end is still accepted.
- DRAIN: fault_detect ignored (no push, no overflow). When count==0 -> DONE.
- DONE: test_end_out=1. Hold until rst.
- ABORT: entered from any state on early_term=1 (priority over test_end). Same edge: queue flushed, count=0. aborted=1, bist_hold=1, fault_valid=0. Hold until rst.
- Pop: fault_valid && bira_ready. The head advances at that edge.
- Merge: the incoming report matches the tail entry on row, col and bank, and count>0 and not (count==1 && pop this cycle). The tail col_flag is ORed with col_flag and no push occurs.
- Push: on a non-merged report, the entry is written at the tail and wr_ptr increments mod DEPTH.
- Full: count==DEPTH with no pop in the same cycle, and the report is not merged. The report is dropped and overflow is set.
- Simultaneous push+pop: count unchanged. This is legal at full and at empty+1.
- Pointers: AW bits, natural wrap. count is AW+1 bits, range 0..DEPTH.
- bist_hold = (count >= DEPTH-2) in COLLECT, 1 in ABORT, 0 otherwise.

## Timing
- Reset values:
  - state=COLLECT, pointers=0, count=0.
  - fault_valid=0, bist_hold=0, test_end_out=0, aborted=0, overflow=0.
  - Data outputs are 0.
- Show-ahead head: data outputs are combinational from RAM[rd_ptr] and are stable while fault_valid=1 && bira_ready=0.
- Push latency: a report on cycle N is visible on fault_valid/data at cycle N+1 when the queue was empty.
- A merge into the head entry updates col_flag_out at the next edge. BIRA may see the flag widen while waiting.
- test_end_out rises on the edge following the cycle in which the last pop makes count 0 in DRAIN. If the queue is empty when test_end arrives, it rises 2 edges after test_end (COLLECT->DRAIN->DONE).
- aborted and fault_valid=0 appear 1 cycle after early_term.
- Reset mid-operation discards all contents. overflow is cleared only by rst.

## Test plan
- Single fault: rst, then fault_detect with row=0x155, col=0x0AA, flag=0x01, bank=2, bira_ready=1.
  - Required: fault_valid=1 next cycle with those values, popped the same cycle, count returns to 0.
- Merge: three consecutive reports at row=5, col=9, bank=1 with flags 0x01, 0x04, 0x80, bira_ready=0.
  - Required: count=1, col_flag_out=0x85.
  - Then a report at row=6: count=2.
- Fill/overflow: 10 distinct reports with bira_ready=0.
  - Required: bist_hold=1 at count=6, count saturates at 8, overflow=1.
  - Draining with bira_ready=1 returns the first 8 in order.
- Full push+pop: at count=8, a distinct report with bira_ready=1.
  - Required: count stays 8, overflow stays 0, new entry is last out.
- End of test: 3 buffered entries, test_end=1, then pop one per cycle.
  - Required: fault_detect ignored during DRAIN, test_end_out=1 one edge after the third pop.
- Abort: 5 buffered entries, early_term=1.
  - Required: next cycle count=0, fault_valid=0, aborted=1, bist_hold=1.
  - test_end afterward has no effect until rst.

Source files
------------

// File: rtl/bira_fault_buffer.sv
// Elastic fault queue between the BIST engine and BIRA.
// Captures fault reports, merges back-to-back repeats of the same cell group into the tail entry,
// presents the head over valid/ready, throttles BIST when nearly full and forwards end-of-test
// only once every buffered fault has been consumed.
module bira_fault_buffer #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          fault_detect,
  input  logic [9:0]    row_add_in,
  input  logic [9:0]    col_add_in,
  input  logic [7:0]    col_flag,
  input  logic [1:0]    bank_in,
  input  logic          test_end,
  input  logic          early_term,
  input  logic          bira_ready,
  output logic          fault_valid,
  output logic [9:0]    row_addr,
  output logic [9:0]    col_addr,
  output logic [7:0]    col_flag_out,
  output logic [1:0]    bank_addr,
  output logic          bist_hold,
  output logic          test_end_out,
  output logic          aborted,
  output logic          overflow,
  output logic [AW:0]   count
);

  localparam logic [AW:0] FullCount = (AW+1)'(DEPTH);
  localparam logic [AW:0] HoldCount = (AW+1)'(DEPTH - 2);
  localparam logic [AW:0] OneCount  = (AW+1)'(1);

  typedef enum logic [1:0] {StCollect, StDrain, StDone, StAbort} state_e;

  state_e        r_state;
  logic [9:0]    r_row_mem  [DEPTH];
  logic [9:0]    r_col_mem  [DEPTH];
  logic [7:0]    r_flag_mem [DEPTH];
  logic [1:0]    r_bank_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          r_overflow;

  logic          w_valid;
  logic          w_pop;
  logic          w_accept;
  logic [AW-1:0] w_tail_ptr;
  logic          w_tail_match;
  logic          w_merge;
  logic          w_full;
  logic          w_push;
  logic          w_drop;

  // Handshake, merge and push/drop decisions for the current cycle.
  always_comb begin
    w_valid    = (r_count != '0) && (r_state != StAbort);
    w_pop      = w_valid && bira_ready;
    // Abort wins over everything, so a report in the abort cycle is never stored.
    w_accept   = fault_detect && (r_state == StCollect) && !early_term;
    w_tail_ptr = r_wr_ptr - 1'b1;
    w_tail_match = (r_row_mem[w_tail_ptr] == row_add_in) &&
                   (r_col_mem[w_tail_ptr] == col_add_in) &&
                   (r_bank_mem[w_tail_ptr] == bank_in);
    // A sole entry leaving this cycle cannot absorb the report; it becomes a fresh push.
    w_merge    = w_accept && w_tail_match && (r_count != '0) &&
                 !((r_count == OneCount) && w_pop);
    w_full     = (r_count == FullCount) && !w_pop;
    w_push     = w_accept && !w_merge && !w_full;
    w_drop     = w_accept && !w_merge && w_full;
  end

  // Entry storage: write new reports at the tail, OR merged flags into the tail entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_push) begin
        r_row_mem[r_wr_ptr]  <= row_add_in;
        r_col_mem[r_wr_ptr]  <= col_add_in;
        r_flag_mem[r_wr_ptr] <= col_flag;
        r_bank_mem[r_wr_ptr] <= bank_in;
      end else if (w_merge) begin
        r_flag_mem[w_tail_ptr] <= r_flag_mem[w_tail_ptr] | col_flag;
      end
    end
  end

  // Control FSM with pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= StCollect;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (early_term) begin
      r_state  <= StAbort;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
      if (w_drop) r_overflow <= 1'b1;
      unique case (r_state)
        StCollect: if (test_end) r_state <= StDrain;
        StDrain:   if (r_count == '0) r_state <= StDone;
        StDone:    r_state <= StDone;
        StAbort:   r_state <= StAbort;
        default:   r_state <= StCollect;
      endcase
    end
  end

  // Show-ahead head entry and status outputs; data reads as zero while the queue is empty.
  always_comb begin
    fault_valid  = w_valid;
    row_addr     = w_valid ? r_row_mem[r_rd_ptr]  : '0;
    col_addr     = w_valid ? r_col_mem[r_rd_ptr]  : '0;
    col_flag_out = w_valid ? r_flag_mem[r_rd_ptr] : '0;
    bank_addr    = w_valid ? r_bank_mem[r_rd_ptr] : '0;
    unique case (r_state)
      StCollect: bist_hold = (r_count >= HoldCount);
      StAbort:   bist_hold = 1'b1;
      default:   bist_hold = 1'b0;
    endcase
    test_end_out = (r_state == StDone);
    aborted      = (r_state == StAbort);
    overflow     = r_overflow;
    count        = r_count;
  end

endmodule
